// File: rtl/mem_io_arbiter_pkg.sv
// mem_io_arbiter_pkg: shared IO map, memory width and arbiter state encoding.
package mem_io_arbiter_pkg;
    localparam logic [31:0] IO_BASE  = 32'hFFFF_FC00;
    localparam logic [9:0]  LED_OFFS = 10'h060;
    localparam logic [9:0]  SW_OFFS  = 10'h070;
    localparam int          MEM_AW   = 14;
    typedef enum logic [1:0] {ST_BOOT, ST_IDLE, ST_RD_WAIT, ST_HANDOFF} state_t;
endpackage

// File: rtl/io_sync2.sv
// io_sync2: two-flop synchroniser for asynchronous switch pins.
module io_sync2 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_s1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            o_q  <= '0;
        end else begin
            r_s1 <= i_d;
            o_q  <= r_s1;
        end
    end
endmodule

// File: rtl/mem_io_arbiter.sv
// mem_io_arbiter: shares the data-memory port between CPU and UART loader,
// decodes memory-mapped IO and stalls the CPU across memory read latency.
module mem_io_arbiter #(
    parameter logic [31:0] IO_BASE  = mem_io_arbiter_pkg::IO_BASE,
    parameter logic [9:0]  LED_OFFS = mem_io_arbiter_pkg::LED_OFFS,
    parameter logic [9:0]  SW_OFFS  = mem_io_arbiter_pkg::SW_OFFS,
    parameter int          MEM_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_cpu_mread,
    input  logic        i_cpu_mwrite,
    input  logic [31:0] i_cpu_addr,
    input  logic [31:0] i_cpu_wdata,
    output logic [31:0] o_cpu_rdata,
    output logic        o_cpu_stall,
    input  logic        i_ld_active,
    input  logic        i_ld_we,
    input  logic [13:0] i_ld_addr,
    input  logic [31:0] i_ld_wdata,
    output logic        o_ld_grant,
    output logic        o_mem_en,
    output logic        o_mem_we,
    output logic [13:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic [15:0] i_sw_in,
    output logic [15:0] o_led_out,
    output logic        o_err
);
    import mem_io_arbiter_pkg::*;

    state_t      r_state;
    logic [1:0]  r_cnt;
    logic        r_done;
    logic [31:0] r_rdata;
    logic [15:0] r_led;
    logic        r_err;
    logic [15:0] w_sw;
    logic [9:0]  w_offs;
    logic        w_io, w_wr, w_rd, w_req, w_led_hit, w_sw_hit, w_unmapped;
    logic        w_boot, w_idle, w_mem_rd, w_mem_wr;
    logic [31:0] w_io_rdata;

    io_sync2 #(.W(16)) u_sync (.clk(clk), .rst_n(rst_n), .i_d(i_sw_in), .o_q(w_sw));

    // A simultaneous read+write is handled as a write.
    always_comb begin
        w_io       = i_cpu_addr >= IO_BASE;
        w_offs     = 10'(i_cpu_addr - IO_BASE);
        w_wr       = i_cpu_mwrite;
        w_rd       = i_cpu_mread & ~i_cpu_mwrite;
        w_req      = i_cpu_mread | i_cpu_mwrite;
        w_led_hit  = w_io & (w_offs == LED_OFFS);
        w_sw_hit   = w_io & (w_offs == SW_OFFS);
        w_unmapped = w_io & ~w_led_hit & ~w_sw_hit;
        w_boot     = r_state == ST_BOOT;
        w_idle     = r_state == ST_IDLE;
        w_mem_rd   = w_idle & w_rd & ~w_io;
        w_mem_wr   = w_idle & w_wr & ~w_io;
        w_io_rdata = w_sw_hit ? {16'h0, w_sw} : w_led_hit ? {16'h0, r_led} : 32'h0;
    end

    // Memory outputs are forced low while reset is asserted so an aborted cycle cannot write.
    always_comb begin
        o_mem_en    = rst_n & (w_boot ? i_ld_we : (w_mem_rd | w_mem_wr));
        o_mem_we    = rst_n & (w_boot ? i_ld_we : w_mem_wr);
        o_mem_addr  = !rst_n ? '0 : w_boot ? i_ld_addr : i_cpu_addr[MEM_AW+1:2];
        o_mem_wdata = !rst_n ? '0 : w_boot ? i_ld_wdata : i_cpu_wdata;
        o_ld_grant  = w_boot;
        o_cpu_stall = w_boot | (r_state == ST_HANDOFF) | ((r_state == ST_RD_WAIT) & ~r_done) | w_mem_rd;
        o_cpu_rdata = (w_idle & w_rd & w_io) ? w_io_rdata : r_rdata;
        o_led_out   = r_led;
        o_err       = r_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_rdata <= '0;
            r_led   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: if (!i_ld_active) r_state <= ST_IDLE;
                ST_IDLE: begin
                    if (w_mem_rd) begin
                        r_state <= ST_RD_WAIT;
                        r_cnt   <= 2'(MEM_LAT - 1);
                        r_done  <= 1'b0;
                    end else if (i_ld_active) begin
                        r_state <= ST_HANDOFF;
                    end
                    if (w_wr & w_led_hit) r_led <= i_cpu_wdata[15:0];
                    if ((w_req & w_unmapped) | (i_cpu_mread & i_cpu_mwrite)) r_err <= 1'b1;
                end
                ST_RD_WAIT: begin
                    // Capture at count zero, then give the CPU one unstalled cycle to consume it.
                    if (r_done) begin
                        r_done  <= 1'b0;
                        r_state <= i_ld_active ? ST_HANDOFF : ST_IDLE;
                    end else if (r_cnt == 2'd0) begin
                        r_rdata <= i_mem_rdata;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                ST_HANDOFF: r_state <= ST_BOOT;
            endcase
        end
    end
endmodule
